// File: rtl/pipe_regs.sv
// pipe_regs: F, D and E pipeline registers for the Y86-64 pipeline.
// Each register loads, holds or takes a NOP bubble on every rising edge as
// directed by the hazard-control requests. Saturating stall/bubble counters
// and a sticky illegal-control flag are kept for debug and performance work.
// There is no handshake: every register updates on every edge, and all
// outputs come straight from flops.
module pipe_regs #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             F_stall,
    input  logic             D_stall,
    input  logic             D_bubble,
    input  logic             E_bubble,

    input  logic [63:0]      f_predPC,
    input  logic [3:0]       f_stat,
    input  logic [3:0]       f_icode,
    input  logic [3:0]       f_ifun,
    input  logic [3:0]       f_rA,
    input  logic [3:0]       f_rB,
    input  logic [63:0]      f_valC,
    input  logic [63:0]      f_valP,

    input  logic [3:0]       d_icode,
    input  logic [3:0]       d_ifun,
    input  logic [3:0]       d_dstE,
    input  logic [3:0]       d_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       d_stat,
    input  logic [63:0]      d_valC,
    input  logic [63:0]      d_valA,
    input  logic [63:0]      d_valB,

    output logic [63:0]      F_predPC,

    output logic [3:0]       D_stat,
    output logic [3:0]       D_icode,
    output logic [3:0]       D_ifun,
    output logic [3:0]       D_rA,
    output logic [3:0]       D_rB,
    output logic [63:0]      D_valC,
    output logic [63:0]      D_valP,

    output logic [3:0]       E_stat,
    output logic [3:0]       E_icode,
    output logic [3:0]       E_ifun,
    output logic [3:0]       E_dstE,
    output logic [3:0]       E_dstM,
    output logic [3:0]       E_srcA,
    output logic [3:0]       E_srcB,
    output logic [63:0]      E_valC,
    output logic [63:0]      E_valA,
    output logic [63:0]      E_valB,

    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic             ctl_err
);

    // Bubble (NOP) encoding shared by D and E.
    localparam logic [3:0] STAT_AOK = 4'h1;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] FN_NONE  = 4'h0;
    localparam logic [3:0] RNONE    = 4'hF;
    localparam logic [63:0] VAL_ZERO = 64'h0;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Decoded D-register action; stall always wins over bubble.
    logic d_load_f;
    logic d_load_bubble;
    logic ctl_conflict;

    // Next values for the D register.
    logic [3:0]  dn_stat;
    logic [3:0]  dn_icode;
    logic [3:0]  dn_ifun;
    logic [3:0]  dn_ra;
    logic [3:0]  dn_rb;
    logic [63:0] dn_valc;
    logic [63:0] dn_valp;

    // Next values for the E register.
    logic [3:0]  en_stat;
    logic [3:0]  en_icode;
    logic [3:0]  en_ifun;
    logic [3:0]  en_dste;
    logic [3:0]  en_dstm;
    logic [3:0]  en_srca;
    logic [3:0]  en_srcb;
    logic [63:0] en_valc;
    logic [63:0] en_vala;
    logic [63:0] en_valb;

    // Next values for the event counters.
    logic [CNT_W-1:0] stall_cnt_nx;
    logic [CNT_W-1:0] bubble_cnt_nx;

    // Resolve the D-register action from the stall/bubble pair.
    always_comb begin
        d_load_f      = !D_stall && !D_bubble;
        d_load_bubble = !D_stall && D_bubble;
        ctl_conflict  = D_stall && D_bubble;
    end

    // D next value: hold by default, then bubble or fetch results.
    always_comb begin
        dn_stat  = D_stat;
        dn_icode = D_icode;
        dn_ifun  = D_ifun;
        dn_ra    = D_rA;
        dn_rb    = D_rB;
        dn_valc  = D_valC;
        dn_valp  = D_valP;
        if (d_load_bubble) begin
            dn_stat  = STAT_AOK;
            dn_icode = I_NOP;
            dn_ifun  = FN_NONE;
            dn_ra    = RNONE;
            dn_rb    = RNONE;
            dn_valc  = VAL_ZERO;
            dn_valp  = VAL_ZERO;
        end else if (d_load_f) begin
            dn_stat  = f_stat;
            dn_icode = f_icode;
            dn_ifun  = f_ifun;
            dn_ra    = f_rA;
            dn_rb    = f_rB;
            dn_valc  = f_valC;
            dn_valp  = f_valP;
        end
    end

    // E next value: E never holds, it takes either a bubble or decode results.
    always_comb begin
        en_stat  = d_stat;
        en_icode = d_icode;
        en_ifun  = d_ifun;
        en_dste  = d_dstE;
        en_dstm  = d_dstM;
        en_srca  = d_srcA;
        en_srcb  = d_srcB;
        en_valc  = d_valC;
        en_vala  = d_valA;
        en_valb  = d_valB;
        if (E_bubble) begin
            en_stat  = STAT_AOK;
            en_icode = I_NOP;
            en_ifun  = FN_NONE;
            en_dste  = RNONE;
            en_dstm  = RNONE;
            en_srca  = RNONE;
            en_srcb  = RNONE;
            en_valc  = VAL_ZERO;
            en_vala  = VAL_ZERO;
            en_valb  = VAL_ZERO;
        end
    end

    // Saturating increments: counters stop at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_nx  = stall_cnt;
        bubble_cnt_nx = bubble_cnt;
        if (F_stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt_nx = stall_cnt + CNT_W'(1);
        end
        if (E_bubble && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt_nx = bubble_cnt + CNT_W'(1);
        end
    end

    // F register: predicted PC, held while fetch is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            F_predPC <= 64'h0;
        end else if (!F_stall) begin
            F_predPC <= f_predPC;
        end
    end

    // D register: resets to the bubble value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            D_stat  <= STAT_AOK;
            D_icode <= I_NOP;
            D_ifun  <= FN_NONE;
            D_rA    <= RNONE;
            D_rB    <= RNONE;
            D_valC  <= VAL_ZERO;
            D_valP  <= VAL_ZERO;
        end else begin
            D_stat  <= dn_stat;
            D_icode <= dn_icode;
            D_ifun  <= dn_ifun;
            D_rA    <= dn_ra;
            D_rB    <= dn_rb;
            D_valC  <= dn_valc;
            D_valP  <= dn_valp;
        end
    end

    // E register: resets to the bubble value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            E_stat  <= STAT_AOK;
            E_icode <= I_NOP;
            E_ifun  <= FN_NONE;
            E_dstE  <= RNONE;
            E_dstM  <= RNONE;
            E_srcA  <= RNONE;
            E_srcB  <= RNONE;
            E_valC  <= VAL_ZERO;
            E_valA  <= VAL_ZERO;
            E_valB  <= VAL_ZERO;
        end else begin
            E_stat  <= en_stat;
            E_icode <= en_icode;
            E_ifun  <= en_ifun;
            E_dstE  <= en_dste;
            E_dstM  <= en_dstm;
            E_srcA  <= en_srca;
            E_srcB  <= en_srcb;
            E_valC  <= en_valc;
            E_valA  <= en_vala;
            E_valB  <= en_valb;
        end
    end

    // Stall and bubble event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            stall_cnt  <= stall_cnt_nx;
            bubble_cnt <= bubble_cnt_nx;
        end
    end

    // Sticky flag for a simultaneous D stall and D bubble request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctl_err <= 1'b0;
        end else if (ctl_conflict) begin
            ctl_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_regs.sv
// tb_pipe_regs: directed bench for pipe_regs. The driver pushes the expected
// full output state of each edge into exp_q; a monitor pops and compares it
// after every rising edge. Directed spot checks cover the named scenarios.
module tb_pipe_regs;

    localparam int CNT_W = 4;
    localparam int W     = 441;

    localparam logic [147:0] BUB_D = {4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0};
    localparam logic [219:0] BUB_E = {4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF,
                                      64'h0, 64'h0, 64'h0};

    logic clk;
    logic rst;
    logic F_stall, D_stall, D_bubble, E_bubble;
    logic [63:0] f_predPC;
    logic [3:0]  f_stat, f_icode, f_ifun, f_rA, f_rB;
    logic [63:0] f_valC, f_valP;
    logic [3:0]  d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB, d_stat;
    logic [63:0] d_valC, d_valA, d_valB;
    logic [63:0] F_predPC;
    logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [63:0] E_valC, E_valA, E_valB;
    logic [CNT_W-1:0] stall_cnt, bubble_cnt;
    logic ctl_err;

    logic [W-1:0] exp_q[$];
    int vectors;
    int miscompares;

    // Reference state
    logic [63:0]  m_pc;
    logic [147:0] m_d;
    logic [219:0] m_e;
    logic [3:0]   m_sc, m_bc;
    logic         m_err;

    pipe_regs #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .f_predPC(f_predPC), .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun),
        .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP),
        .d_icode(d_icode), .d_ifun(d_ifun), .d_dstE(d_dstE), .d_dstM(d_dstM),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_stat(d_stat),
        .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
        .F_predPC(F_predPC),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_dstE(E_dstE),
        .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .ctl_err(ctl_err)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] pack_dut();
        return {F_predPC, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
                E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB,
                E_valC, E_valA, E_valB, stall_cnt, bubble_cnt, ctl_err};
    endfunction

    // Driver tasks
    task automatic set_ctl(input logic fs, input logic ds, input logic db, input logic eb);
        F_stall = fs; D_stall = ds; D_bubble = db; E_bubble = eb;
    endtask

    task automatic set_f(input logic [63:0] pc, input logic [3:0] st, input logic [3:0] ic,
                         input logic [3:0] fn, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] vc, input logic [63:0] vp);
        f_predPC = pc; f_stat = st; f_icode = ic; f_ifun = fn;
        f_rA = ra; f_rB = rb; f_valC = vc; f_valP = vp;
    endtask

    task automatic set_d(input logic [3:0] st, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [3:0] de, input logic [3:0] dm, input logic [3:0] sa,
                         input logic [3:0] sb, input logic [63:0] vc, input logic [63:0] va,
                         input logic [63:0] vb);
        d_stat = st; d_icode = ic; d_ifun = fn; d_dstE = de; d_dstM = dm;
        d_srcA = sa; d_srcB = sb; d_valC = vc; d_valA = va; d_valB = vb;
    endtask

    task automatic model_reset();
        m_pc = 64'h0; m_d = BUB_D; m_e = BUB_E; m_sc = 4'h0; m_bc = 4'h0; m_err = 1'b0;
    endtask

    // Advance the reference by one edge with the current inputs, queue the
    // expected state, and return at the next falling edge.
    task automatic step();
        if (!F_stall) m_pc = f_predPC;
        if (!D_stall) begin
            if (D_bubble) m_d = BUB_D;
            else m_d = {f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP};
        end
        if (E_bubble) m_e = BUB_E;
        else m_e = {d_stat, d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB,
                    d_valC, d_valA, d_valB};
        if (F_stall && m_sc != 4'hF) m_sc = m_sc + 4'h1;
        if (E_bubble && m_bc != 4'hF) m_bc = m_bc + 4'h1;
        if (D_stall && D_bubble) m_err = 1'b1;
        exp_q.push_back({m_pc, m_d, m_e, m_sc, m_bc, m_err});
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: one expected state per rising edge out of reset
    always @(posedge clk) begin
        logic [W-1:0] got;
        logic [W-1:0] exp;
        #1;
        if (!rst && exp_q.size() > 0) begin
            got = pack_dut();
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL state at %0t: got %h expected %h", $time, got, exp);
            end
        end
    end

    // Directed stimulus
    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        set_ctl(0, 0, 0, 0);
        set_f(64'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0);
        set_d(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0, 64'h0);
        model_reset();

        // Reset values before any clock edge
        #3;
        check("reset_F_predPC", F_predPC, 64'h0);
        check("reset_D_icode", {60'h0, D_icode}, 64'h1);
        check("reset_D_rA", {60'h0, D_rA}, 64'hF);
        check("reset_E_stat", {60'h0, E_stat}, 64'h1);
        check("reset_E_dstM", {60'h0, E_dstM}, 64'hF);
        check("reset_stall_cnt", {60'h0, stall_cnt}, 64'h0);
        check("reset_bubble_cnt", {60'h0, bubble_cnt}, 64'h0);
        check("reset_ctl_err", {63'h0, ctl_err}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Straight flow
        set_f(64'h100, 4'h1, 4'h6, 4'h0, 4'h2, 4'h3, 64'h10, 64'h10A);
        set_d(4'h1, 4'h2, 4'h0, 4'h3, 4'hF, 4'h1, 4'h2, 64'h0, 64'h5, 64'h7);
        step();
        check("flow_D_icode", {60'h0, D_icode}, 64'h6);
        check("flow_D_valC", D_valC, 64'h10);
        check("flow_E_valA", E_valA, 64'h5);
        check("flow_F_predPC", F_predPC, 64'h100);

        // Load/use hazard
        set_ctl(1, 1, 0, 1);
        set_f(64'h200, 4'h1, 4'hA, 4'h0, 4'h5, 4'h6, 64'h20, 64'h20A);
        step();
        check("lu_F_predPC", F_predPC, 64'h100);
        check("lu_D_icode", {60'h0, D_icode}, 64'h6);
        check("lu_D_valP", D_valP, 64'h10A);
        check("lu_E_icode", {60'h0, E_icode}, 64'h1);
        check("lu_E_valA", E_valA, 64'h0);
        check("lu_stall_cnt", {60'h0, stall_cnt}, 64'h1);
        check("lu_bubble_cnt", {60'h0, bubble_cnt}, 64'h1);

        // Mispredicted branch
        set_ctl(0, 0, 1, 1);
        set_f(64'h300, 4'h1, 4'h3, 4'h0, 4'h1, 4'h1, 64'h30, 64'h30A);
        set_d(4'h1, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 4'hF, 64'h88, 64'h0, 64'h0);
        step();
        check("mp_D_icode", {60'h0, D_icode}, 64'h1);
        check("mp_D_rA", {60'h0, D_rA}, 64'hF);
        check("mp_E_icode", {60'h0, E_icode}, 64'h1);
        check("mp_F_predPC", F_predPC, 64'h300);
        check("mp_bubble_cnt", {60'h0, bubble_cnt}, 64'h2);

        // Known D contents ahead of the illegal combination
        set_ctl(0, 0, 0, 0);
        set_f(64'h400, 4'h1, 4'h2, 4'h0, 4'h1, 4'h2, 64'h44, 64'h40A);
        step();
        check("pre_D_icode", {60'h0, D_icode}, 64'h2);

        // Illegal combination: stall wins, flag is sticky
        set_ctl(0, 1, 1, 0);
        set_f(64'h500, 4'h1, 4'h9, 4'h0, 4'h3, 4'h4, 64'h55, 64'h50A);
        step();
        check("ill_D_icode", {60'h0, D_icode}, 64'h2);
        check("ill_D_valC", D_valC, 64'h44);
        check("ill_ctl_err", {63'h0, ctl_err}, 64'h1);
        set_ctl(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            set_f(64'h600 + 64'(i), 4'h1, 4'h5, 4'h0, 4'h0, 4'h1, 64'(i), 64'h0);
            step();
            check("ill_ctl_err_sticky", {63'h0, ctl_err}, 64'h1);
        end

        // Mixed control patterns, checked by the scoreboard
        for (int i = 0; i < 8; i++) begin
            set_ctl(i[0], i[1], i[2] & ~i[1], i[2]);
            set_f(64'h1000 + 64'(i * 8), 4'h1, 4'(i + 2), 4'(i), 4'(i), 4'(15 - i),
                  64'($urandom_range(0, 65535)), 64'h1000 + 64'(i));
            set_d(4'h1, 4'(i + 1), 4'h0, 4'(i), 4'hF, 4'(i + 3), 4'(i + 4),
                  64'(i * 3), 64'(i * 5), 64'(i * 7));
            step();
        end

        // Reset during a stall, asserted mid-cycle
        set_ctl(1, 0, 0, 0);
        set_f(64'h700, 4'h1, 4'h6, 4'h0, 4'h1, 4'h2, 64'h77, 64'h70A);
        step();
        #2;
        rst = 1'b1;
        #1;
        check("rst2_F_predPC", F_predPC, 64'h0);
        check("rst2_D_icode", {60'h0, D_icode}, 64'h1);
        check("rst2_E_stat", {60'h0, E_stat}, 64'h1);
        check("rst2_E_dstM", {60'h0, E_dstM}, 64'hF);
        check("rst2_stall_cnt", {60'h0, stall_cnt}, 64'h0);
        check("rst2_ctl_err", {63'h0, ctl_err}, 64'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        set_f(64'h800, 4'h1, 4'h6, 4'h0, 4'h1, 4'h2, 64'h88, 64'h80A);
        step();
        check("post_rst_F_predPC", F_predPC, 64'h0);
        check("post_rst_stall_cnt", {60'h0, stall_cnt}, 64'h1);
        set_ctl(0, 0, 0, 0);
        step();
        check("post_rst_load", F_predPC, 64'h800);

        // Saturation: 20 stalled/bubbled edges on 4-bit counters
        set_ctl(1, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            step();
        end
        check("sat_stall_cnt", {60'h0, stall_cnt}, 64'hF);
        check("sat_bubble_cnt", {60'h0, bubble_cnt}, 64'hF);

        // Let the monitor drain the last expected state
        set_ctl(0, 0, 0, 0);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
